imuldiv_int_div_iterative: RTL

- Iterative 32-bit integer divider; inverse-operation counterpart to the iterative multiplier in the imuldiv unit.
- Uses the same val/rdy request/response protocol, so the two can sit side by side behind the muldiv dispatcher.
- Restoring shift-subtract algorithm, one quotient bit per cycle, with a signed or unsigned mode.
- Returns remainder and quotient packed into a single 64-bit response.

---
 rtl/imuldiv_int_div_iterative_if.sv | 19 +
 rtl/imuldiv_int_div_iterative.sv | 57 +++++
 2 files changed

// File: rtl/imuldiv_int_div_iterative_if.sv
// imuldiv_int_div_iterative_if: val/rdy request/response bundle for the iterative divider
interface imuldiv_int_div_iterative_if;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;
  modport master (
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    input  divreq_rdy, divresp_msg_result, divresp_val
  );
  modport slave (
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    output divreq_rdy, divresp_msg_result, divresp_val
  );
endinterface

// File: rtl/imuldiv_int_div_iterative.sv
// imuldiv_int_div_iterative: restoring shift-subtract 32-bit divider, one quotient bit per cycle
module imuldiv_int_div_iterative (
  input logic                           clk,
  input logic                           reset,
  imuldiv_int_div_iterative_if.slave    div
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state, state_next;
  logic [63:0] a_reg, b_reg, a_sh;
  logic [64:0] diff;
  logic [31:0] a_mag, b_mag, quot, rem;
  logic [5:0]  count;
  logic        sign_a, sign_b, fn_reg, go;
  assign go = div.divreq_val && div.divreq_rdy;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_next;
  always_comb
    state_next = (state == IDLE && go)               ? CALC :
                 (state == CALC && count == 6'd1)    ? DONE :
                 (state == DONE && div.divresp_rdy)  ? IDLE : state;
  always_comb begin
    div.divreq_rdy  = state == IDLE;
    div.divresp_val = state == DONE;
  end
  always_comb begin
    a_mag = (div.divreq_msg_fn && div.divreq_msg_a[31]) ? -div.divreq_msg_a : div.divreq_msg_a;
    b_mag = (div.divreq_msg_fn && div.divreq_msg_b[31]) ? -div.divreq_msg_b : div.divreq_msg_b;
    a_sh  = a_reg << 1;
    diff  = {1'b0, a_sh} - {1'b0, b_reg};
  end
  // operands are held as magnitudes; signs are reapplied only on the way out
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      count  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      fn_reg <= 1'b0;
    end else if (go) begin
      sign_a <= div.divreq_msg_fn & div.divreq_msg_a[31];
      sign_b <= div.divreq_msg_fn & div.divreq_msg_b[31];
      fn_reg <= div.divreq_msg_fn;
      a_reg  <= {32'b0, a_mag};
      b_reg  <= {b_mag, 32'b0};
      count  <= 6'd32;
    end else if (state == CALC) begin
      a_reg <= diff[64] ? a_sh : {diff[63:1], 1'b1};
      count <= count - 6'd1;
    end
  end
  always_comb begin
    quot = (fn_reg && (sign_a ^ sign_b)) ? -a_reg[31:0] : a_reg[31:0];
    rem  = (fn_reg && sign_a) ? -a_reg[63:32] : a_reg[63:32];
    div.divresp_msg_result = {rem, quot};
  end
endmodule
